// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction-fetch port (IF) and the load/store port (LS) share one
// single-port, word-addressed data memory that has a one-cycle registered read.
// Only one access is in flight at a time. The arbiter sequences each access, builds the byte
// enables and lane-replicated store data, and extracts and extends load data according to
// the 3-bit memory-control code.
//
// Ports
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   if_req/if_addr     fetch request, held until if_gnt; word-aligned byte address
//   if_gnt             fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata one-cycle pulse with the fetched word (rdata is 0 otherwise)
//   ls_req/ls_addr/ls_ctrl/ls_wdata
//                      load/store request and its fields, held until ls_gnt
//   ls_gnt             load/store accepted this cycle (combinational)
//   ls_done/ls_rdata   one-cycle completion pulse with extended load data (0 for stores)
//   ls_err             pulses with ls_done for a misaligned access (memory untouched)
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata
//                      memory strobe, write enable, byte lanes, word address, write data
//   mem_rdata          memory read data, valid the cycle after a read strobe
module mem_arbiter #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic [31:0]   ls_addr,
  input  logic [2:0]    ls_ctrl,
  input  logic [31:0]   ls_wdata,
  output logic          ls_gnt,
  output logic          ls_done,
  output logic [31:0]   ls_rdata,
  output logic          ls_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [2:0] CtrlLb  = 3'b000;
  localparam logic [2:0] CtrlLh  = 3'b001;
  localparam logic [2:0] CtrlLw  = 3'b010;
  localparam logic [2:0] CtrlLbu = 3'b011;
  localparam logic [2:0] CtrlLhu = 3'b100;
  localparam logic [2:0] CtrlSb  = 3'b101;
  localparam logic [2:0] CtrlSh  = 3'b110;
  localparam logic [2:0] CtrlSw  = 3'b111;

  typedef enum logic [1:0] {StIdle, StAcc, StResp, StErr} state_e;

  state_e        state_q, state_d;
  logic          last_was_ls_q, last_was_ls_d;
  logic          sel_ls_q, sel_ls_d;       // owner of the access in flight
  logic [AW+1:0] addr_q, addr_d;           // only the bits that reach the memory are kept
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          store_done_q, store_done_d;

  logic          grant_ls, grant_if;
  logic          is_store;
  logic          ls_misaligned;
  logic [31:0]   lane_word;
  logic [31:0]   load_data;

  // Upper address bits wrap; they are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], ls_addr[31:AW+2]};

  // Arbitration: a lone requester wins; on contention LS wins unless it won last time.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if ((state_q == StIdle) && !rst) begin
      grant_ls = ls_req && (!if_req || !last_was_ls_q);
      grant_if = if_req && !grant_ls;
    end
  end

  assign if_gnt = grant_if;
  assign ls_gnt = grant_ls;

  // Fetches are never checked for alignment.
  always_comb begin
    ls_misaligned = 1'b0;
    unique case (ls_ctrl)
      CtrlLh, CtrlLhu, CtrlSh: ls_misaligned = ls_addr[0];
      CtrlLw, CtrlSw:          ls_misaligned = (ls_addr[1:0] != 2'b00);
      default:                 ls_misaligned = 1'b0;
    endcase
  end

  assign is_store = sel_ls_q && (ctrl_q == CtrlSb || ctrl_q == CtrlSh || ctrl_q == CtrlSw);

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    last_was_ls_d = last_was_ls_q;
    sel_ls_d      = sel_ls_q;
    addr_d        = addr_q;
    ctrl_d        = ctrl_q;
    wdata_d       = wdata_q;
    store_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_ls) begin
          sel_ls_d      = 1'b1;
          addr_d        = ls_addr[AW+1:0];
          ctrl_d        = ls_ctrl;
          wdata_d       = ls_wdata;
          last_was_ls_d = 1'b1;
          state_d       = ls_misaligned ? StErr : StAcc;
        end else if (grant_if) begin
          sel_ls_d      = 1'b0;
          addr_d        = if_addr[AW+1:0];
          ctrl_d        = CtrlLw;        // a fetch is a plain word read
          wdata_d       = 32'h0;
          last_was_ls_d = 1'b0;
          state_d       = StAcc;
        end
      end
      StAcc: begin
        if (is_store) begin
          // Completion is signalled in the following IDLE cycle, which may grant again.
          store_done_d = 1'b1;
          state_d      = StIdle;
        end else begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_was_ls_q <= 1'b0;
      sel_ls_q      <= 1'b0;
      addr_q        <= '0;
      ctrl_q        <= 3'b000;
      wdata_q       <= 32'h0;
      store_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_was_ls_q <= last_was_ls_d;
      sel_ls_q      <= sel_ls_d;
      addr_q        <= addr_d;
      ctrl_q        <= ctrl_d;
      wdata_q       <= wdata_d;
      store_done_q  <= store_done_d;
    end
  end

  // Memory interface: driven only during the single ACC cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (state_q == StAcc) begin
      mem_en   = 1'b1;
      mem_addr = addr_q[AW+1:2];
      mem_be   = 4'hF;
      if (is_store) begin
        mem_we = 1'b1;
        unique case (ctrl_q)
          CtrlSb: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          CtrlSh: begin
            mem_be    = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'hF;
            mem_wdata = wdata_q;
          end
        endcase
      end
    end
  end

  // Load lane extraction: bring the addressed lane down to bit 0, then extend.
  assign lane_word = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = 32'h0;
    unique case (ctrl_q)
      CtrlLb:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      CtrlLh:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      CtrlLw:  load_data = mem_rdata;
      CtrlLbu: load_data = {24'h0, lane_word[7:0]};
      CtrlLhu: load_data = {16'h0, lane_word[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // Response outputs; data lines are held at zero outside their valid pulse.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'h0;
    ls_done   = store_done_q;
    ls_err    = 1'b0;
    ls_rdata  = 32'h0;
    unique case (state_q)
      StResp: begin
        if (sel_ls_q) begin
          ls_done  = 1'b1;
          ls_rdata = load_data;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
      StErr: begin
        ls_done = 1'b1;
        ls_err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
